// File: rtl/banked_spram.sv
// Banked single-port scratchpad shared by two requesters (A, B).
// Words are interleaved across N_BANK banks on the low address bits. Each bank
// serves one access per cycle, and a 1-bit round-robin pointer settles
// same-bank conflicts. Read data returns after 1 or 2 cycles (OUT_REG).
module banked_spram #(
    parameter int unsigned W_DATA  = 32,
    parameter int unsigned W_WORD  = 8,
    parameter int unsigned N_BANK  = 4,
    parameter int unsigned OUT_REG = 0
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                a_req,
    input  logic                a_we,
    input  logic [W_WORD-1:0]   a_addr,
    input  logic [W_DATA/8-1:0] a_be,
    input  logic [W_DATA-1:0]   a_din,
    output logic                a_gnt,
    output logic                a_rvalid,
    output logic [W_DATA-1:0]   a_dout,
    input  logic                b_req,
    input  logic                b_we,
    input  logic [W_WORD-1:0]   b_addr,
    input  logic [W_DATA/8-1:0] b_be,
    input  logic [W_DATA-1:0]   b_din,
    output logic                b_gnt,
    output logic                b_rvalid,
    output logic [W_DATA-1:0]   b_dout
);

    localparam int unsigned W_BE   = W_DATA / 8;
    localparam int unsigned W_BANK = $clog2(N_BANK);
    localparam int unsigned W_ROW  = W_WORD - W_BANK;
    localparam int unsigned D_BANK = 2 ** W_ROW;

    localparam logic PRIO_A = 1'b0;
    localparam logic PRIO_B = 1'b1;

    logic [W_BANK-1:0] a_bank;
    logic [W_BANK-1:0] b_bank;
    logic [W_ROW-1:0]  a_row;
    logic [W_ROW-1:0]  b_row;

    assign a_bank = a_addr[W_BANK-1:0];
    assign b_bank = b_addr[W_BANK-1:0];
    assign a_row  = a_addr[W_WORD-1:W_BANK];
    assign b_row  = b_addr[W_WORD-1:W_BANK];

    logic prio_q;
    logic prio_d;
    logic conflict_c;

    // Grant arbitration: both ports win unless they collide on a bank; prio flips only on a collision.
    always_comb begin
        conflict_c = a_req && b_req && (a_bank == b_bank);
        prio_d     = prio_q;
        a_gnt      = 1'b0;
        b_gnt      = 1'b0;
        if (rstn) begin
            a_gnt = a_req && (!conflict_c || (prio_q == PRIO_A));
            b_gnt = b_req && (!conflict_c || (prio_q == PRIO_B));
            if (conflict_c) begin
                prio_d = ~prio_q;
            end
        end
    end

    // Round-robin pointer, starts at port A.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            prio_q <= PRIO_A;
        end else begin
            prio_q <= prio_d;
        end
    end

    logic [W_DATA-1:0] bank_rdata [N_BANK];

    for (genvar g = 0; g < N_BANK; g++) begin : g_bank
        logic [W_DATA-1:0] mem [D_BANK];
        logic              sel_a;
        logic              sel_b;
        logic              wen;
        logic [W_ROW-1:0]  row;
        logic [W_BE-1:0]   be;
        logic [W_DATA-1:0] din;

        // Single access port per bank, steered by whichever requester was granted this bank.
        always_comb begin
            sel_a = a_gnt && (a_bank == W_BANK'(g));
            sel_b = b_gnt && (b_bank == W_BANK'(g));
            row   = sel_a ? a_row : b_row;
            wen   = sel_a ? a_we : (sel_b && b_we);
            be    = sel_a ? a_be : b_be;
            din   = sel_a ? a_din : b_din;
        end

        // Byte-masked write; the array itself is never reset.
        always_ff @(posedge clk) begin
            if (wen) begin
                for (int unsigned i = 0; i < W_BE; i++) begin
                    if (be[i]) begin
                        mem[row][i*8 +: 8] <= din[i*8 +: 8];
                    end
                end
            end
        end

        assign bank_rdata[g] = mem[row];
    end

    logic [1:0]             rd_c;
    logic [1:0][W_DATA-1:0] rdata_c;
    logic [1:0]             rv1_q;
    logic [1:0]             rv1_d;
    logic [1:0][W_DATA-1:0] do1_q;
    logic [1:0][W_DATA-1:0] do1_d;
    logic [1:0]             rv_out;
    logic [1:0][W_DATA-1:0] do_out;

    // First read stage: capture the granted bank word; hold data when idle.
    always_comb begin
        rd_c[0]    = a_gnt && !a_we;
        rd_c[1]    = b_gnt && !b_we;
        rdata_c[0] = bank_rdata[a_bank];
        rdata_c[1] = bank_rdata[b_bank];
        rv1_d      = rd_c;
        do1_d      = do1_q;
        for (int p = 0; p < 2; p++) begin
            if (rd_c[p]) begin
                do1_d[p] = rdata_c[p];
            end
        end
    end

    // First read stage registers, cleared by reset so no in-flight read survives it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rv1_q <= '0;
            do1_q <= '0;
        end else begin
            rv1_q <= rv1_d;
            do1_q <= do1_d;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [1:0]             rv2_q;
        logic [1:0]             rv2_d;
        logic [1:0][W_DATA-1:0] do2_q;
        logic [1:0][W_DATA-1:0] do2_d;

        // Optional second stage: forwards valid reads, holds data otherwise.
        always_comb begin
            rv2_d = rv1_q;
            do2_d = do2_q;
            for (int p = 0; p < 2; p++) begin
                if (rv1_q[p]) begin
                    do2_d[p] = do1_q[p];
                end
            end
        end

        // Second stage registers.
        always_ff @(posedge clk) begin
            if (!rstn) begin
                rv2_q <= '0;
                do2_q <= '0;
            end else begin
                rv2_q <= rv2_d;
                do2_q <= do2_d;
            end
        end

        assign rv_out = rv2_q;
        assign do_out = do2_q;
    end else begin : g_no_out_reg
        assign rv_out = rv1_q;
        assign do_out = do1_q;
    end

    assign a_rvalid = rv_out[0];
    assign b_rvalid = rv_out[1];
    assign a_dout   = do_out[0];
    assign b_dout   = do_out[1];

endmodule

// File: tb/tb_banked_spram.sv
// Bench for banked_spram: two instances (OUT_REG=0 and OUT_REG=1) share one
// stimulus stream. A reference memory and prio model predict grants; every
// granted read is queued with its due cycle and checked when it falls due.
module tb_banked_spram;

    logic        clk = 1'b0;
    logic        rstn;
    logic        a_req, a_we, b_req, b_we;
    logic [7:0]  a_addr, b_addr;
    logic [3:0]  a_be, b_be;
    logic [31:0] a_din, b_din;
    logic        a_gnt0, b_gnt0, a_gnt1, b_gnt1;
    logic        rv [4];
    logic [31:0] dv [4];

    always #5 clk = ~clk;

    banked_spram #(.W_DATA(32), .W_WORD(8), .N_BANK(4), .OUT_REG(0)) u_dut0 (
        .clk(clk), .rstn(rstn),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_be(a_be), .a_din(a_din),
        .a_gnt(a_gnt0), .a_rvalid(rv[0]), .a_dout(dv[0]),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_be(b_be), .b_din(b_din),
        .b_gnt(b_gnt0), .b_rvalid(rv[1]), .b_dout(dv[1])
    );

    banked_spram #(.W_DATA(32), .W_WORD(8), .N_BANK(4), .OUT_REG(1)) u_dut1 (
        .clk(clk), .rstn(rstn),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_be(a_be), .a_din(a_din),
        .a_gnt(a_gnt1), .a_rvalid(rv[2]), .a_dout(dv[2]),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_be(b_be), .b_din(b_din),
        .b_gnt(b_gnt1), .b_rvalid(rv[3]), .b_dout(dv[3])
    );

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        q [4][$];
    logic [31:0] last [4];
    logic [31:0] mref [256];
    logic        prio_m;
    int          cyc;
    int          n_chk;
    int          n_bad;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h exp %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Output checks for the last edge, then model the coming edge.
    always @(negedge clk) begin
        logic conf, ega, egb;
        if (cyc > 0) begin
            for (int k = 0; k < 4; k++) begin
                if (q[k].size() > 0 && q[k][0].due == cyc) begin
                    chk($sformatf("rvalid[%0d]", k), 32'(rv[k]), 32'd1);
                    chk($sformatf("dout[%0d]", k), dv[k], q[k][0].data);
                    last[k] = q[k][0].data;
                    void'(q[k].pop_front());
                end else begin
                    chk($sformatf("rvalid_idle[%0d]", k), 32'(rv[k]), 32'd0);
                    chk($sformatf("dout_hold[%0d]", k), dv[k], last[k]);
                end
            end
        end
        conf = a_req && b_req && (a_addr[1:0] == b_addr[1:0]);
        ega  = rstn && a_req && (!conf || prio_m == 1'b0);
        egb  = rstn && b_req && (!conf || prio_m == 1'b1);
        chk("a_gnt0", 32'(a_gnt0), 32'(ega));
        chk("b_gnt0", 32'(b_gnt0), 32'(egb));
        chk("a_gnt1", 32'(a_gnt1), 32'(ega));
        chk("b_gnt1", 32'(b_gnt1), 32'(egb));
        if (!rstn) begin
            prio_m = 1'b0;
            for (int k = 0; k < 4; k++) begin
                while (q[k].size() > 0 && q[k][$].due >= cyc + 1) void'(q[k].pop_back());
                last[k] = '0;
            end
        end else begin
            if (ega && !a_we) begin
                q[0].push_back('{mref[a_addr], cyc + 1});
                q[2].push_back('{mref[a_addr], cyc + 2});
            end
            if (egb && !b_we) begin
                q[1].push_back('{mref[b_addr], cyc + 1});
                q[3].push_back('{mref[b_addr], cyc + 2});
            end
            for (int j = 0; j < 4; j++) begin
                if (ega && a_we && a_be[j]) mref[a_addr][j*8 +: 8] = a_din[j*8 +: 8];
                if (egb && b_we && b_be[j]) mref[b_addr][j*8 +: 8] = b_din[j*8 +: 8];
            end
            if (conf) prio_m = ~prio_m;
        end
    end

    task automatic put(input logic aq, input logic awe, input logic [7:0] aad,
                       input logic [3:0] abe, input logic [31:0] adin,
                       input logic bq, input logic bwe, input logic [7:0] bad,
                       input logic [3:0] bbe, input logic [31:0] bdin);
        a_req = aq; a_we = awe; a_addr = aad; a_be = abe; a_din = adin;
        b_req = bq; b_we = bwe; b_addr = bad; b_be = bbe; b_din = bdin;
    endtask

    task automatic idle();
        put(1'b0, 1'b0, 8'h00, 4'h0, 32'h0, 1'b0, 1'b0, 8'h00, 4'h0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] t3_b;
        logic [5:0] t3_ga;
        logic [5:0] t3_gb;
        n_chk  = 0;
        n_bad  = 0;
        cyc    = 0;
        prio_m = 1'b0;
        for (int k = 0; k < 4; k++) last[k] = '0;
        for (int i = 0; i < 256; i++) mref[i] = '0;

        // Reset with both ports requesting the same bank
        rstn = 1'b0;
        put(1'b1, 1'b1, 8'h00, 4'hF, 32'hA0A0A0A0, 1'b1, 1'b1, 8'h10, 4'hF, 32'hB1B1B1B1);
        tick();
        chk("rst_a_gnt", 32'(a_gnt0), 32'd0);
        chk("rst_b_gnt", 32'(b_gnt0), 32'd0);
        chk("rst_rvalid", 32'(rv[0]), 32'd0);
        chk("rst_dout", dv[0], 32'd0);
        tick();
        rstn = 1'b1;
        #1;
        chk("t1_first_a", 32'(a_gnt0), 32'd1);
        chk("t1_first_b", 32'(b_gnt0), 32'd0);
        tick();
        put(1'b1, 1'b1, 8'h20, 4'hF, 32'hC2C2C2C2, 1'b1, 1'b1, 8'h10, 4'hF, 32'hB1B1B1B1);
        #1;
        chk("t1_second_b", 32'(b_gnt0), 32'd1);
        tick();
        put(1'b1, 1'b1, 8'h20, 4'hF, 32'hC2C2C2C2, 1'b0, 1'b0, 8'h00, 4'h0, 32'h0);
        tick();

        // Fill low memory through both ports in parallel (always different banks)
        for (int i = 0; i < 16; i++) begin
            put(1'b1, 1'b1, 8'(i), 4'hF, $urandom,
                1'b1, 1'b1, 8'(8'h10 + ((i + 1) % 16)), 4'hF, $urandom);
            tick();
        end

        // Parallel writes then reads on different banks
        put(1'b1, 1'b1, 8'h04, 4'hF, 32'hDEADBEEF, 1'b1, 1'b1, 8'h05, 4'hF, 32'h12345678);
        #1;
        chk("t2_a_gnt", 32'(a_gnt0), 32'd1);
        chk("t2_b_gnt", 32'(b_gnt0), 32'd1);
        tick();
        put(1'b1, 1'b0, 8'h04, 4'h0, 32'h0, 1'b1, 1'b0, 8'h05, 4'h0, 32'h0);
        tick();
        idle();
        chk("t2_a_rvalid", 32'(rv[0]), 32'd1);
        chk("t2_a_dout", dv[0], 32'hDEADBEEF);
        chk("t2_b_dout", dv[1], 32'h12345678);
        tick();

        // Conflict round-robin with one non-conflict cycle in the middle
        t3_b  = 6'b011011;
        t3_ga = 6'b101101;
        t3_gb = 6'b010010;
        for (int c = 0; c < 6; c++) begin
            put(1'b1, 1'b0, 8'h00, 4'h0, 32'h0, t3_b[c], 1'b0, 8'h10, 4'h0, 32'h0);
            #1;
            chk($sformatf("t3_a_gnt%0d", c), 32'(a_gnt0), 32'(t3_ga[c]));
            chk($sformatf("t3_b_gnt%0d", c), 32'(b_gnt0), 32'(t3_gb[c]));
            tick();
        end
        idle();
        tick();

        // Byte enables
        put(1'b1, 1'b1, 8'h20, 4'hF, 32'hFFFFFFFF, 1'b0, 1'b0, 8'h00, 4'h0, 32'h0);
        tick();
        put(1'b1, 1'b1, 8'h20, 4'b0101, 32'h00000000, 1'b0, 1'b0, 8'h00, 4'h0, 32'h0);
        tick();
        put(1'b1, 1'b0, 8'h20, 4'h0, 32'h0, 1'b0, 1'b0, 8'h00, 4'h0, 32'h0);
        tick();
        chk("t4_be_mask", dv[0], 32'hFF00FF00);
        put(1'b1, 1'b1, 8'h20, 4'h0, 32'h12345678, 1'b0, 1'b0, 8'h00, 4'h0, 32'h0);
        tick();
        put(1'b1, 1'b0, 8'h20, 4'h0, 32'h0, 1'b0, 1'b0, 8'h00, 4'h0, 32'h0);
        tick();
        chk("t4_be_zero", dv[0], 32'hFF00FF00);
        idle();
        tick();

        // Streamed reads on A; the registered-output instance lags by one more cycle
        for (int i = 0; i < 8; i++) begin
            put(1'b1, 1'b0, 8'(i), 4'h0, 32'h0, 1'b0, 1'b0, 8'h00, 4'h0, 32'h0);
            tick();
            if (i == 0) chk("t5_lat1_not_yet", 32'(rv[2]), 32'd0);
            if (i == 1) chk("t5_lat2_valid", 32'(rv[2]), 32'd1);
        end
        idle();
        repeat (3) tick();

        // Reset right after a read grant
        put(1'b1, 1'b0, 8'h04, 4'h0, 32'h0, 1'b0, 1'b0, 8'h00, 4'h0, 32'h0);
        tick();
        rstn = 1'b0;
        idle();
        tick();
        chk("t6_rvalid_rst", 32'(rv[2]), 32'd0);
        chk("t6_dout_rst", dv[2], 32'd0);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_rvalid_after", 32'(rv[2]), 32'd0);
            chk("t6_dout_after", dv[2], 32'd0);
        end

        repeat (4) tick();
        for (int k = 0; k < 4; k++) chk($sformatf("drain[%0d]", k), 32'(q[k].size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
